// File: rtl/des_final_permutation.sv
// des_final_permutation: bit-serial DES inverse initial permutation with ap_* block handshake
module des_final_permutation #(
  parameter bit SWAP_HALVES = 1'b1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [31:0] L16,
  input  logic [31:0] R16,
  output logic [63:0] ap_return
);
  typedef enum logic [2:0] {IDLE = 3'b001, RD = 3'b010, SH = 3'b100} state_t;
  state_t      r_state, w_next;
  logic [6:0]  r_idx;
  logic [63:0] r_pre, r_acc;
  logic [5:0]  r_q, w_rom, w_sel;
  logic        w_ce, w_load;
  assign ap_idle = (r_state == IDLE) && !ap_start;
  assign w_load  = (r_state == IDLE) && ap_start;
  assign w_sel   = 6'd63 - r_q;
  // FP table stored as zero-based source positions (FP[i]-1)
  always_comb begin
    w_rom = 6'd0;
    case (r_idx[5:0])
      6'd0:  w_rom = 6'd39; 6'd1:  w_rom = 6'd7;  6'd2:  w_rom = 6'd47; 6'd3:  w_rom = 6'd15;
      6'd4:  w_rom = 6'd55; 6'd5:  w_rom = 6'd23; 6'd6:  w_rom = 6'd63; 6'd7:  w_rom = 6'd31;
      6'd8:  w_rom = 6'd38; 6'd9:  w_rom = 6'd6;  6'd10: w_rom = 6'd46; 6'd11: w_rom = 6'd14;
      6'd12: w_rom = 6'd54; 6'd13: w_rom = 6'd22; 6'd14: w_rom = 6'd62; 6'd15: w_rom = 6'd30;
      6'd16: w_rom = 6'd37; 6'd17: w_rom = 6'd5;  6'd18: w_rom = 6'd45; 6'd19: w_rom = 6'd13;
      6'd20: w_rom = 6'd53; 6'd21: w_rom = 6'd21; 6'd22: w_rom = 6'd61; 6'd23: w_rom = 6'd29;
      6'd24: w_rom = 6'd36; 6'd25: w_rom = 6'd4;  6'd26: w_rom = 6'd44; 6'd27: w_rom = 6'd12;
      6'd28: w_rom = 6'd52; 6'd29: w_rom = 6'd20; 6'd30: w_rom = 6'd60; 6'd31: w_rom = 6'd28;
      6'd32: w_rom = 6'd35; 6'd33: w_rom = 6'd3;  6'd34: w_rom = 6'd43; 6'd35: w_rom = 6'd11;
      6'd36: w_rom = 6'd51; 6'd37: w_rom = 6'd19; 6'd38: w_rom = 6'd59; 6'd39: w_rom = 6'd27;
      6'd40: w_rom = 6'd34; 6'd41: w_rom = 6'd2;  6'd42: w_rom = 6'd42; 6'd43: w_rom = 6'd10;
      6'd44: w_rom = 6'd50; 6'd45: w_rom = 6'd18; 6'd46: w_rom = 6'd58; 6'd47: w_rom = 6'd26;
      6'd48: w_rom = 6'd33; 6'd49: w_rom = 6'd1;  6'd50: w_rom = 6'd41; 6'd51: w_rom = 6'd9;
      6'd52: w_rom = 6'd49; 6'd53: w_rom = 6'd17; 6'd54: w_rom = 6'd57; 6'd55: w_rom = 6'd25;
      6'd56: w_rom = 6'd32; 6'd57: w_rom = 6'd0;  6'd58: w_rom = 6'd40; 6'd59: w_rom = 6'd8;
      6'd60: w_rom = 6'd48; 6'd61: w_rom = 6'd16; 6'd62: w_rom = 6'd56; 6'd63: w_rom = 6'd24;
      default: w_rom = 6'd0;
    endcase
  end
  // synchronous ROM read port, enabled only in RD
  always_ff @(posedge ap_clk) begin
    if (w_ce) r_q <= w_rom;
  end
  // state register
  always_ff @(posedge ap_clk) begin
    r_state <= ap_rst ? IDLE : w_next;
  end
  // next state and handshake outputs
  always_comb begin
    w_next   = r_state;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    w_ce     = 1'b0;
    case (r_state)
      IDLE: w_next = ap_start ? RD : IDLE;
      RD: begin
        if (r_idx == 7'd64) begin
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          w_next   = IDLE;
        end else begin
          w_ce   = 1'b1;
          w_next = SH;
        end
      end
      SH:      w_next = RD;
      default: w_next = IDLE;
    endcase
  end
  // datapath: latch halves at start, shift one permuted bit per SH, publish at done
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_idx     <= 7'd0;
      r_pre     <= 64'd0;
      r_acc     <= 64'd0;
      ap_return <= 64'd0;
    end else begin
      if (w_load) begin
        r_pre <= SWAP_HALVES ? {R16, L16} : {L16, R16};
        r_idx <= 7'd0;
        r_acc <= 64'd0;
      end
      if (r_state == SH) begin
        r_acc <= {r_acc[62:0], r_pre[w_sel]};
        r_idx <= r_idx + 7'd1;
      end
      if (ap_done) ap_return <= r_acc;
    end
  end
endmodule

// File: tb/tb_des_final_permutation.sv
// tb_des_final_permutation: random and directed checks of the serial FP against a table model
module tb_des_final_permutation;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] l16 = 32'd0, r16 = 32'd0;
  logic        done0, idle0, ready0, done1, idle1, ready1;
  logic [63:0] ret0, ret1;
  int          n_vec = 0, n_err = 0;
  localparam int FP[64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                            38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                            36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                            34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  always #5 clk = ~clk;
  des_final_permutation #(.SWAP_HALVES(1'b1)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done0), .ap_idle(idle0),
    .ap_ready(ready0), .L16(l16), .R16(r16), .ap_return(ret0));
  des_final_permutation #(.SWAP_HALVES(1'b0)) dut_ns (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done1), .ap_idle(idle1),
    .ap_ready(ready1), .L16(r16), .R16(l16), .ap_return(ret1));
  function automatic logic [63:0] fp_model(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] pre, res;
    pre = {r, l};
    for (int j = 0; j < 64; j++) res[63-j] = pre[64-FP[j]];
    return res;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] e;
    int n;
    e = fp_model(l, r);
    @(negedge clk);
    l16 = l; r16 = r; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (n == 3) check("busy_idle", {63'd0, idle0}, 64'd0);
      if (n == 5) begin l16 = $urandom; r16 = $urandom; end
    end while (!done0 && n < 200);
    check("latency", n, 129);
    check("ready", {62'd0, ready0, done1}, 64'd3);
    @(negedge clk);
    check("ret", ret0, e);
    check("ret_noswap", ret1, e);
    check("done_width", {62'd0, done0, ready0}, 64'd0);
    check("idle_after", {62'd0, idle0, idle1}, 64'd3);
  endtask
  initial begin
    int n, t1, nd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ret", ret0, 64'd0);
    check("rst_flags", {61'd0, done0, ready0, idle0}, 64'd1);
    rst = 1'b0;
    do_op(32'h43423234, 32'h0A4CD995);
    check("fips", ret0, 64'h85E813540F0AB405);
    check("fips_noswap", ret1, 64'h85E813540F0AB405);
    do_op(32'h00000000, 32'h80000000);
    do_op(32'h00000001, 32'h00000000);
    do_op(32'h00000000, 32'h00000000);
    check("zeros", ret0, 64'd0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    check("ones", ret0, 64'hFFFFFFFFFFFFFFFF);
    for (int k = 0; k < 32; k++) do_op(1 << k, 32'd0);
    for (int k = 0; k < 10; k++) do_op($urandom, $urandom);
    // back-to-back with ap_start held high
    @(negedge clk);
    l16 = 32'h43423234; r16 = 32'h0A4CD995; start = 1'b1;
    n = 0; t1 = 0; nd = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 5) begin l16 = 32'hFFFFFFFF; r16 = 32'hFFFFFFFF; end
      if (done0) begin
        nd++;
        if (nd == 1) t1 = n;
        else start = 1'b0;
      end
      if (nd == 1 && n == t1 + 1) check("b2b_first", ret0, 64'h85E813540F0AB405);
    end while (nd < 2 && n < 400);
    check("b2b_lat1", t1, 129);
    check("b2b_gap", n - t1, 130);
    @(negedge clk);
    check("b2b_second", ret0, 64'hFFFFFFFFFFFFFFFF);
    check("b2b_second_ns", ret1, 64'hFFFFFFFFFFFFFFFF);
    // reset in the middle of an operation
    @(negedge clk);
    l16 = $urandom; r16 = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ret", ret0, 64'd0);
    check("abort_idle", {62'd0, idle0, done0}, 64'd2);
    nd = 0;
    repeat (150) begin
      @(negedge clk);
      if (done0 || done1) nd++;
    end
    check("abort_nodone", nd, 0);
    do_op(32'h43423234, 32'h0A4CD995);
    check("fips_after_rst", ret0, 64'h85E813540F0AB405);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
